sensor_command_sequencer: RTL and testbench

Sequences one request/response transaction per received UART packet. It sits between the UART receiver, the DHT11 sensor interface, the command decode table and the UART transmitter. It validates the command/address pair, triggers a sensor read when one is needed, and drives the decode table's enables and operand registers. It then captures the 16-bit response and hands it to the transmitter, repeating measurements periodically while continuous sensing is active.

---
 rtl/sensor_command_sequencer_if.sv | 50 +++++
 rtl/sensor_command_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_sensor_command_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_command_sequencer_if.sv
// Bus bundle between the command sequencer and its UART RX/TX, DHT11 reader
// and command decode table neighbours.
interface sensor_command_sequencer_if;
    // UART receiver side
    logic        rx_valid;
    logic [7:0]  rx_command;
    logic [7:0]  rx_address;
    logic        rx_ready;
    // DHT11 reader side
    logic        sensor_start;
    logic [7:0]  sensor_address;
    logic        sensor_done;
    logic        sensor_error;
    logic [39:0] sensor_data;
    // Decode table side
    logic [7:0]  exe_command;
    logic [7:0]  exe_address;
    logic [7:0]  next_command;
    logic [7:0]  next_address;
    logic [39:0] data_sensor;
    logic        crt_decoder;
    logic        command_invalid;
    logic [15:0] buffer_tx;
    // UART transmitter side
    logic [15:0] tx_data;
    logic        tx_start;
    logic        tx_busy;

    // Sequencer view
    modport master (
        input  rx_valid, rx_command, rx_address,
        input  sensor_done, sensor_error, sensor_data,
        input  buffer_tx, tx_busy,
        output rx_ready, sensor_start, sensor_address,
        output exe_command, exe_address, next_command, next_address,
        output data_sensor, crt_decoder, command_invalid,
        output tx_data, tx_start
    );

    // Surrounding-blocks view
    modport slave (
        output rx_valid, rx_command, rx_address,
        output sensor_done, sensor_error, sensor_data,
        output buffer_tx, tx_busy,
        input  rx_ready, sensor_start, sensor_address,
        input  exe_command, exe_address, next_command, next_address,
        input  data_sensor, crt_decoder, command_invalid,
        input  tx_data, tx_start
    );
endinterface

// File: rtl/sensor_command_sequencer.sv
// One request/response transaction per received UART packet: validate,
// optionally read the DHT11, enable the decode table, transmit the answer,
// and repeat measurements periodically in continuous mode.
// Optional macro SENSOR_TIMEOUT_EN: adds a watchdog on sensor reads.
module sensor_command_sequencer #(
    parameter int unsigned NUM_SENSORS    = 32,
    parameter int unsigned CONT_PERIOD    = 50_000_000,
    parameter int unsigned SENSOR_TIMEOUT = 2_000_000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    sensor_command_sequencer_if.master bus
);

    localparam int unsigned PER_W = $clog2(CONT_PERIOD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SENSOR_REQ,
        S_SENSOR_WAIT,
        S_DECODE,
        S_TX_REQ,
        S_TX_WAIT,
        S_CONT_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         exe_command_q, exe_command_d;
    logic [7:0]         exe_address_q, exe_address_d;
    logic [7:0]         next_command_q, next_command_d;
    logic [7:0]         next_address_q, next_address_d;
    logic [39:0]        data_sensor_q, data_sensor_d;
    logic [15:0]        tx_data_q, tx_data_d;
    logic               rx_ready_q, rx_ready_d;
    logic               sensor_start_q, sensor_start_d;
    logic               crt_decoder_q, crt_decoder_d;
    logic               command_invalid_q, command_invalid_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_seen_q, busy_seen_d;
    logic [PER_W-1:0]   period_cnt_q, period_cnt_d;
    logic               timeout_c;
    logic               rx_bad_c;
    logic               disable_match_c;

`ifdef SENSOR_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(SENSOR_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Watchdog counts cycles spent waiting for the sensor
    always_comb begin
        to_cnt_d  = '0;
        timeout_c = 1'b0;
        if (state_q == S_SENSOR_WAIT) begin
            to_cnt_d  = to_cnt_q + TO_W'(1);
            timeout_c = (to_cnt_q == TO_W'(SENSOR_TIMEOUT - 1));
        end
    end

    // Watchdog register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end
`else
    // Without the watchdog a read only ends on sensor_done or reset
    logic unused_timeout;
    assign timeout_c      = 1'b0;
    assign unused_timeout = ^32'(SENSOR_TIMEOUT);
`endif

    // Packet classification helpers
    assign rx_bad_c = (bus.rx_command == 8'd0) || (bus.rx_command >= 8'd8) ||
                      (32'(bus.rx_address) >= NUM_SENSORS);
    assign disable_match_c = (((exe_command_q == 8'd4) && (bus.rx_command == 8'd6)) ||
                              ((exe_command_q == 8'd5) && (bus.rx_command == 8'd7))) &&
                             (bus.rx_address == exe_address_q);

    // Next-state and registered-output logic
    always_comb begin
        state_d           = state_q;
        exe_command_d     = exe_command_q;
        exe_address_d     = exe_address_q;
        next_command_d    = next_command_q;
        next_address_d    = next_address_q;
        data_sensor_d     = data_sensor_q;
        tx_data_d         = tx_data_q;
        sensor_start_d    = 1'b0;
        crt_decoder_d     = 1'b0;
        command_invalid_d = 1'b0;
        tx_start_d        = 1'b0;
        busy_seen_d       = busy_seen_q;
        period_cnt_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    exe_command_d  = bus.rx_command;
                    exe_address_d  = bus.rx_address;
                    next_command_d = 8'd0;
                    next_address_d = 8'd0;
                    if (rx_bad_c) begin
                        command_invalid_d = 1'b1;
                        state_d           = S_DECODE;
                    end else if ((bus.rx_command == 8'd6) || (bus.rx_command == 8'd7)) begin
                        crt_decoder_d = 1'b1;
                        state_d       = S_DECODE;
                    end else begin
                        sensor_start_d = 1'b1;
                        state_d        = S_SENSOR_REQ;
                    end
                end
            end
            S_SENSOR_REQ: begin
                state_d = S_SENSOR_WAIT;
            end
            S_SENSOR_WAIT: begin
                if (bus.sensor_done) begin
                    data_sensor_d = bus.sensor_error ? 40'hFF_FFFF_FFFF : bus.sensor_data;
                    crt_decoder_d = 1'b1;
                    state_d       = S_DECODE;
                end else if (timeout_c) begin
                    data_sensor_d = 40'hFF_FFFF_FFFF;
                    crt_decoder_d = 1'b1;
                    state_d       = S_DECODE;
                end
            end
            S_DECODE, S_TX_REQ: begin
                // tx_start is raised the cycle after DECODE when the UART is free
                if (state_q == S_DECODE) tx_data_d = bus.buffer_tx;
                busy_seen_d = 1'b0;
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = S_TX_WAIT;
                end else begin
                    state_d    = S_TX_REQ;
                end
            end
            S_TX_WAIT: begin
                if (bus.tx_busy) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
                    next_command_d = 8'd0;
                    state_d = ((exe_command_q == 8'd4) || (exe_command_q == 8'd5)) ?
                              S_CONT_WAIT : S_IDLE;
                end
            end
            S_CONT_WAIT: begin
                period_cnt_d = period_cnt_q + PER_W'(1);
                if (bus.rx_valid) begin
                    // A packet beats a simultaneous period expiry
                    period_cnt_d   = '0;
                    next_command_d = bus.rx_command;
                    next_address_d = bus.rx_address;
                    if (disable_match_c) begin
                        exe_command_d = bus.rx_command;
                        crt_decoder_d = 1'b1;
                        state_d       = S_DECODE;
                    end else begin
                        sensor_start_d = 1'b1;
                        state_d        = S_SENSOR_REQ;
                    end
                end else if (period_cnt_q == PER_W'(CONT_PERIOD - 1)) begin
                    next_command_d = 8'd0;
                    sensor_start_d = 1'b1;
                    state_d        = S_SENSOR_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rx_ready_d = (state_d == S_IDLE) || (state_d == S_CONT_WAIT);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_IDLE;
            exe_command_q     <= '0;
            exe_address_q     <= '0;
            next_command_q    <= '0;
            next_address_q    <= '0;
            data_sensor_q     <= '0;
            tx_data_q         <= '0;
            rx_ready_q        <= 1'b0;
            sensor_start_q    <= 1'b0;
            crt_decoder_q     <= 1'b0;
            command_invalid_q <= 1'b0;
            tx_start_q        <= 1'b0;
            busy_seen_q       <= 1'b0;
            period_cnt_q      <= '0;
        end else begin
            state_q           <= state_d;
            exe_command_q     <= exe_command_d;
            exe_address_q     <= exe_address_d;
            next_command_q    <= next_command_d;
            next_address_q    <= next_address_d;
            data_sensor_q     <= data_sensor_d;
            tx_data_q         <= tx_data_d;
            rx_ready_q        <= rx_ready_d;
            sensor_start_q    <= sensor_start_d;
            crt_decoder_q     <= crt_decoder_d;
            command_invalid_q <= command_invalid_d;
            tx_start_q        <= tx_start_d;
            busy_seen_q       <= busy_seen_d;
            period_cnt_q      <= period_cnt_d;
        end
    end

    assign bus.rx_ready        = rx_ready_q;
    assign bus.sensor_start    = sensor_start_q;
    assign bus.sensor_address  = exe_address_q;
    assign bus.exe_command     = exe_command_q;
    assign bus.exe_address     = exe_address_q;
    assign bus.next_command    = next_command_q;
    assign bus.next_address    = next_address_q;
    assign bus.data_sensor     = data_sensor_q;
    assign bus.crt_decoder     = crt_decoder_q;
    assign bus.command_invalid = command_invalid_q;
    assign bus.tx_data         = tx_data_q;
    assign bus.tx_start        = tx_start_q;

endmodule

// File: tb/tb_sensor_command_sequencer.sv
// Directed bench for sensor_command_sequencer with simple UART TX and
// decode-table models around it.
module tb_sensor_command_sequencer;

    localparam int unsigned NUM_SENSORS    = 32;
    localparam int unsigned CONT_PERIOD    = 100;
    localparam int unsigned SENSOR_TIMEOUT = 200;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_pass;
    int   n_sstart;
    int   n_txstart;
    int   tx_cnt;
    logic tx_hold;
    int   k;
    int   s0;
    int   t0;

    sensor_command_sequencer_if bus();

    sensor_command_sequencer #(
        .NUM_SENSORS    (NUM_SENSORS),
        .CONT_PERIOD    (CONT_PERIOD),
        .SENSOR_TIMEOUT (SENSOR_TIMEOUT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Transmitter model: busy for four cycles after each start, plus a manual hold
    always @(posedge clock) begin
        if (bus.tx_start)  tx_cnt <= 4;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end
    assign bus.tx_busy = (tx_cnt != 0) || tx_hold;

    // Pulse counters
    always @(posedge clock) begin
        if (bus.sensor_start) n_sstart  <= n_sstart + 1;
        if (bus.tx_start)     n_txstart <= n_txstart + 1;
    end

    // Decode table model
    always_comb begin
        bus.buffer_tx = 16'h0000;
        if (bus.command_invalid) begin
            bus.buffer_tx = 16'hCFFF;
        end else if (bus.crt_decoder) begin
            if ((bus.next_command != 8'd0) && (bus.next_command != bus.exe_command))
                bus.buffer_tx = {8'h6F, bus.exe_address};
            else if (bus.exe_command == 8'd6)
                bus.buffer_tx = 16'h0BFF;
            else if (bus.exe_command == 8'd7)
                bus.buffer_tx = 16'h0CFF;
            else if (bus.data_sensor == 40'hFF_FFFF_FFFF)
                bus.buffer_tx = 16'h1FFF;
            else if ((bus.exe_command == 8'd1) || (bus.exe_command == 8'd3) || (bus.exe_command == 8'd5))
                bus.buffer_tx = {8'h09, bus.data_sensor[39:32]};
            else
                bus.buffer_tx = {8'h0A, bus.data_sensor[23:16]};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a negedge; the packet is sampled at the following posedge
    task automatic send(input logic [7:0] cmd, input logic [7:0] addr);
        bus.rx_valid   = 1'b1;
        bus.rx_command = cmd;
        bus.rx_address = addr;
        @(negedge clock);
        bus.rx_valid   = 1'b0;
    endtask

    task automatic reply(input logic err, input logic [39:0] data);
        bus.sensor_done  = 1'b1;
        bus.sensor_error = err;
        bus.sensor_data  = data;
        @(negedge clock);
        bus.sensor_done  = 1'b0;
        bus.sensor_error = 1'b0;
    endtask

    task automatic wait_ready(output logic found);
        int n;
        n = 0;
        while (!bus.rx_ready && n < 60) begin
            @(negedge clock);
            n++;
        end
        found = bus.rx_ready;
    endtask

    task automatic wait_tx(input int limit, output logic found);
        int n;
        n = 0;
        while (!bus.tx_start && n < limit) begin
            @(negedge clock);
            n++;
        end
        found = bus.tx_start;
    endtask

    logic ok;

    initial begin
        n_checks = 0; n_pass = 0; n_sstart = 0; n_txstart = 0; tx_cnt = 0; tx_hold = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_command = 8'd0; bus.rx_address = 8'd0;
        bus.sensor_done = 1'b0; bus.sensor_error = 1'b0; bus.sensor_data = 40'd0;
        reset_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("reset_outs", 64'({bus.rx_ready, bus.sensor_start, bus.crt_decoder, bus.command_invalid,
                               bus.tx_start, bus.exe_command, bus.exe_address, bus.next_command,
                               bus.next_address, bus.tx_data}), 64'd0);
        chk("reset_data", 64'(bus.data_sensor), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 64'(bus.rx_ready), 64'd1);

        // Invalid command: decode error, tx two cycles after acceptance
        send(8'h09, 8'h00);
        chk("inv_pulse", 64'({bus.command_invalid, bus.crt_decoder, bus.sensor_start}), 64'b100);
        @(negedge clock);
        chk("inv_tx", 64'({bus.tx_start, bus.command_invalid, bus.tx_data}), 64'({2'b10, 16'hCFFF}));
        wait_ready(ok);
        chk("inv_back_idle", 64'(ok), 64'd1);

        // Address out of range
        send(8'h01, 8'h20);
        chk("addr_range", 64'({bus.command_invalid, bus.sensor_start}), 64'b10);
        wait_ready(ok);

        // Temperature read
        s0 = n_sstart;
        send(8'h02, 8'h01);
        chk("read_start", 64'({bus.sensor_start, bus.rx_ready, bus.sensor_address}), 64'({2'b10, 8'h01}));
        repeat (3) @(negedge clock);
        reply(1'b0, 40'h3700_1A00_51);
        chk("read_decode", 64'({bus.crt_decoder, bus.command_invalid}), 64'b10);
        chk("read_data", 64'(bus.data_sensor), 64'(40'h3700_1A00_51));
        @(negedge clock);
        chk("read_tx", 64'({bus.tx_start, bus.tx_data}), 64'({1'b1, 16'h0A1A}));
        wait_ready(ok);
        chk("read_one_start", 64'(n_sstart - s0), 64'd1);

        // Stray sensor_done in IDLE is ignored
        t0 = n_txstart;
        reply(1'b1, 40'd0);
        repeat (5) @(negedge clock);
        chk("stray_done", 64'({bus.crt_decoder, bus.data_sensor}), 64'({1'b0, 40'h3700_1A00_51}));
        chk("stray_no_tx", 64'(n_txstart - t0), 64'd0);

        // Sensor error
        send(8'h01, 8'h02);
        repeat (2) @(negedge clock);
        reply(1'b1, 40'h1234_5678_9A);
        chk("err_data", 64'(bus.data_sensor), 64'(40'hFF_FFFF_FFFF));
        @(negedge clock);
        chk("err_tx", 64'({bus.tx_start, bus.tx_data}), 64'({1'b1, 16'h1FFF}));
        wait_ready(ok);

        // Transmitter busy delays tx_start
        tx_hold = 1'b1;
        t0 = n_txstart;
        send(8'h06, 8'h00);
        repeat (5) @(negedge clock);
        chk("busy_hold", 64'(n_txstart - t0), 64'd0);
        tx_hold = 1'b0;
        @(negedge clock);
        chk("busy_release_tx", 64'({bus.tx_start, bus.tx_data}), 64'({1'b1, 16'h0BFF}));
        wait_ready(ok);

        // Continuous temperature on address 3
        send(8'h04, 8'h03);
        repeat (2) @(negedge clock);
        reply(1'b0, 40'h2800_1900_41);
        @(negedge clock);
        chk("cont_tx1", 64'({bus.tx_start, bus.tx_data}), 64'({1'b1, 16'h0A19}));
        wait_ready(ok);
        k = 0;
        while (bus.rx_ready && k < 300) begin k++; @(negedge clock); end
        chk("cont_period", 64'(k), 64'(CONT_PERIOD));
        chk("cont_restart", 64'({bus.sensor_start, bus.next_command}), 64'({1'b1, 8'h00}));
        repeat (2) @(negedge clock);
        reply(1'b0, 40'h2900_1A00_43);
        @(negedge clock);
        chk("cont_tx2", 64'({bus.tx_start, bus.tx_data}), 64'({1'b1, 16'h0A1A}));
        wait_ready(ok);

        // Matching disable ends continuous mode without a read
        send(8'h06, 8'h03);
        chk("dis_decode", 64'({bus.crt_decoder, bus.sensor_start, bus.exe_command, bus.next_command}),
            64'({2'b10, 8'h06, 8'h06}));
        @(negedge clock);
        chk("dis_tx", 64'({bus.tx_start, bus.tx_data}), 64'({1'b1, 16'h0BFF}));
        wait_ready(ok);
        s0 = n_sstart;
        repeat (150) @(negedge clock);
        chk("dis_no_reads", 64'({8'(n_sstart - s0), bus.next_command}), 64'd0);

        // Continuous humidity; mismatched disable keeps continuous mode
        send(8'h05, 8'h03);
        repeat (2) @(negedge clock);
        reply(1'b0, 40'h3700_1A00_51);
        @(negedge clock);
        chk("hum_tx", 64'({bus.tx_start, bus.tx_data}), 64'({1'b1, 16'h0937}));
        wait_ready(ok);
        send(8'h07, 8'h05);
        chk("mis_read", 64'({bus.sensor_start, bus.exe_command, bus.next_command, bus.next_address}),
            64'({1'b1, 8'h05, 8'h07, 8'h05}));
        repeat (2) @(negedge clock);
        reply(1'b0, 40'h3700_1A00_51);
        @(negedge clock);
        chk("mis_tx", 64'({bus.tx_start, bus.tx_data}), 64'({1'b1, 16'h6F03}));
        wait_ready(ok);
        k = 0;
        while (bus.rx_ready && k < 300) begin k++; @(negedge clock); end
        chk("mis_cont_kept", 64'({bus.sensor_start, 16'(k)}), 64'({1'b1, 16'(CONT_PERIOD)}));

        // Reset while waiting for the sensor in continuous mode
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outs", 64'({bus.rx_ready, bus.sensor_start, bus.crt_decoder, bus.command_invalid,
                                 bus.tx_start, bus.exe_command, bus.exe_address, bus.next_command,
                                 bus.next_address, bus.tx_data}), 64'd0);
        chk("rst_mid_data", 64'(bus.data_sensor), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        s0 = n_sstart;
        t0 = n_txstart;
        reply(1'b0, 40'h3700_1A00_51);
        repeat (150) @(negedge clock);
        chk("rst_ignored", 64'({8'(n_sstart - s0), 8'(n_txstart - t0), bus.rx_ready}), 64'd1);
        chk("rst_data_zero", 64'(bus.data_sensor), 64'd0);

`ifdef SENSOR_TIMEOUT_EN
        // Watchdog forces an error response
        send(8'h01, 8'h00);
        wait_tx(SENSOR_TIMEOUT + 20, ok);
        chk("timeout_tx", 64'({ok, bus.tx_data}), 64'({1'b1, 16'h1FFF}));
        wait_ready(ok);
`else
        // Without the watchdog the read never finishes on its own
        send(8'h01, 8'h00);
        wait_tx(2 * SENSOR_TIMEOUT, ok);
        chk("no_timeout", 64'({ok, bus.rx_ready}), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
